// File: rtl/conv_filter.sv
// 3x3 convolution filter: box / gaussian / sobel / passthrough kernels in a
// 3-stage pipeline, with per-frame mode latching and line/frame position flags.
module conv_filter #(
    parameter int LINE_WIDTH  = 512,
    parameter int FRAME_LINES = 510
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [71:0] i_pixel_data,
    input  logic        i_pixel_valid,
    input  logic [1:0]  i_mode,
    output logic [7:0]  o_convolved_data,
    output logic        o_convolved_valid,
    output logic        o_line_end,
    output logic        o_frame_done
);
    localparam int CW = (LINE_WIDTH  > 1) ? $clog2(LINE_WIDTH)  : 1;
    localparam int LW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(LINE_WIDTH - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(FRAME_LINES - 1);

    typedef enum logic {F_IDLE, F_ACTIVE} fstate_t;

    fstate_t           state, state_nxt;
    logic [1:0]        act_mode, act_mode_nxt, mode_in;
    logic              latch, last_px;
    logic [CW-1:0]     col;
    logic [LW-1:0]     line;

    logic [8:0][7:0]   win;
    logic [8:0][11:0]  wz;
    logic [3:0][11:0]  part_c, s1_part;
    logic [3:1]        vld_pipe;
    logic [2:1][1:0]   mode_pipe;
    logic signed [11:0] gx, gy;
    logic [11:0]       agx, agy, sum_c, s2_sum;
    logic [7:0]        res_c;

    assign win = i_pixel_data;

    // A window arriving while idle, or alongside the frame's last pixel, opens a new frame.
    assign last_px = o_convolved_valid && (col == COL_LAST) && (line == LINE_LAST);
    assign latch   = i_pixel_valid && ((state == F_IDLE) || last_px);
    assign mode_in = latch ? i_mode : act_mode;

    always_comb begin
        state_nxt    = state;
        act_mode_nxt = act_mode;
        if (latch) begin
            state_nxt    = F_ACTIVE;
            act_mode_nxt = i_mode;
        end else if (last_px) begin
            state_nxt = F_IDLE;
        end
    end

    // S1 partial terms; sobel keeps the four one-sided gradient halves.
    always_comb begin
        for (int k = 0; k < 9; k++) wz[k] = {4'b0, win[k]};
        part_c = '0;
        case (mode_in)
            2'd0: begin
                part_c[0] = wz[0] + wz[1] + wz[2];
                part_c[1] = wz[3] + wz[4] + wz[5];
                part_c[2] = wz[6] + wz[7] + wz[8];
            end
            2'd1: begin
                part_c[0] = wz[0] + (wz[1] << 1) + wz[2];
                part_c[1] = (wz[3] << 1) + (wz[4] << 2) + (wz[5] << 1);
                part_c[2] = wz[6] + (wz[7] << 1) + wz[8];
            end
            2'd2: begin
                part_c[0] = wz[2] + (wz[5] << 1) + wz[8];
                part_c[1] = wz[0] + (wz[3] << 1) + wz[6];
                part_c[2] = wz[6] + (wz[7] << 1) + wz[8];
                part_c[3] = wz[0] + (wz[1] << 1) + wz[2];
            end
            default: part_c[0] = wz[4];
        endcase
    end

    always_comb begin
        gx  = s1_part[0] - s1_part[1];
        gy  = s1_part[2] - s1_part[3];
        agx = gx[11] ? 12'(-gx) : 12'(gx);
        agy = gy[11] ? 12'(-gy) : 12'(gy);
        case (mode_pipe[1])
            2'd2:    sum_c = agx + agy;
            2'd3:    sum_c = s1_part[0];
            default: sum_c = s1_part[0] + s1_part[1] + s1_part[2];
        endcase
    end

    always_comb begin
        case (mode_pipe[2])
            2'd0:    res_c = 8'(s2_sum / 12'd9);
            2'd1:    res_c = 8'(s2_sum >> 4);
            2'd2:    res_c = (s2_sum > 12'd255) ? 8'hFF : 8'(s2_sum);
            default: res_c = 8'(s2_sum);
        endcase
    end

    // Data registers only load behind a valid so bubbles leave the output untouched.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_pipe         <= '0;
            mode_pipe        <= '0;
            s1_part          <= '0;
            s2_sum           <= '0;
            o_convolved_data <= '0;
        end else begin
            vld_pipe <= {vld_pipe[2:1], i_pixel_valid};
            if (i_pixel_valid) begin
                mode_pipe[1] <= mode_in;
                s1_part      <= part_c;
            end
            if (vld_pipe[1]) begin
                mode_pipe[2] <= mode_pipe[1];
                s2_sum       <= sum_c;
            end
            if (vld_pipe[2]) o_convolved_data <= res_c;
        end
    end

    assign o_convolved_valid = vld_pipe[3];
    assign o_line_end        = o_convolved_valid && (col == COL_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= F_IDLE;
            act_mode     <= '0;
            col          <= '0;
            line         <= '0;
            o_frame_done <= 1'b0;
        end else begin
            state        <= state_nxt;
            act_mode     <= act_mode_nxt;
            o_frame_done <= last_px;
            if (o_convolved_valid) begin
                if (col == COL_LAST) begin
                    col  <= '0;
                    line <= (line == LINE_LAST) ? '0 : line + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_filter.sv
// Randomized + directed bench for conv_filter against a cycle-level reference
// built from the kernel arithmetic and the frame/mode rules.
module tb_conv_filter;
    localparam int W = 4;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [71:0] i_pixel_data = '0;
    logic        i_pixel_valid = 1'b1;
    logic [1:0]  i_mode = 2'd0;
    logic [7:0]  o_convolved_data;
    logic        o_convolved_valid, o_line_end, o_frame_done;

    conv_filter #(.LINE_WIDTH(W), .FRAME_LINES(L)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_pixel_data(i_pixel_data),
        .i_pixel_valid(i_pixel_valid), .i_mode(i_mode),
        .o_convolved_data(o_convolved_data), .o_convolved_valid(o_convolved_valid),
        .o_line_end(o_line_end), .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // expected outputs visible after the next rising edge
    bit         e_v, e_le, e_fd;
    logic [7:0] e_d;
    int         col, line;
    bit         active;
    logic [1:0] amode;
    bit         hv[3];
    logic [7:0] hd[3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_px(input logic [71:0] d, input logic [1:0] m);
        int k[9];
        int gx, gy, s;
        for (int i = 0; i < 9; i++) k[i] = int'(d[8*i +: 8]);
        case (m)
            2'd0: s = (k[0]+k[1]+k[2]+k[3]+k[4]+k[5]+k[6]+k[7]+k[8]) / 9;
            2'd1: s = (k[0]+2*k[1]+k[2]+2*k[3]+4*k[4]+2*k[5]+k[6]+2*k[7]+k[8]) / 16;
            2'd2: begin
                gx = (k[2]+2*k[5]+k[8]) - (k[0]+2*k[3]+k[6]);
                gy = (k[6]+2*k[7]+k[8]) - (k[0]+2*k[1]+k[2]);
                s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                if (s > 255) s = 255;
            end
            default: s = k[4];
        endcase
        return 8'(s);
    endfunction

    function automatic logic [71:0] fill(input logic [7:0] b);
        return {9{b}};
    endfunction

    function automatic logic [71:0] rnd_win();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[71:0];
    endfunction

    task automatic cyc(input bit r, input bit v, input logic [71:0] d, input logic [1:0] m);
        bit last, idle;
        logic [1:0] wm;
        @(negedge clk);
        chk("valid", 32'(o_convolved_valid), 32'(e_v));
        chk("data", 32'(o_convolved_data), 32'(e_d));
        chk("line_end", 32'(o_line_end), 32'(e_le));
        chk("frame_done", 32'(o_frame_done), 32'(e_fd));
        i_rst = r; i_pixel_valid = v; i_pixel_data = d; i_mode = m;
        if (r) begin
            e_v = 0; e_le = 0; e_fd = 0; e_d = '0;
            col = 0; line = 0; active = 0; amode = '0;
            for (int i = 0; i < 3; i++) begin hv[i] = 0; hd[i] = '0; end
        end else begin
            last = e_v && col == W-1 && line == L-1;
            idle = !active || last;
            wm   = amode;
            if (v && idle) begin active = 1; amode = m; wm = m; end
            else if (last) active = 0;
            if (e_v) begin
                if (col == W-1) begin col = 0; line = (line == L-1) ? 0 : line + 1; end
                else col++;
            end
            e_fd  = last;
            hv[2] = hv[1]; hd[2] = hd[1];
            hv[1] = hv[0]; hd[1] = hd[0];
            hv[0] = v;     hd[0] = ref_px(d, wm);
            e_v = hv[2];
            if (hv[2]) e_d = hd[2];
            e_le = e_v && col == W-1;
        end
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, rnd_win(), 2'($urandom_range(0, 3)));
    endtask

    task automatic reset_n(input int n);
        for (int i = 0; i < n; i++) cyc(1, 1'($urandom_range(0, 1)), rnd_win(), 2'd0);
    endtask

    logic [71:0] dv;
    logic [1:0]  dm[8];
    logic [71:0] dw[8];

    initial begin
        e_d = '0;
        reset_n(2);
        idle_n(4);

        // single-window kernel cases, each opening a fresh frame after reset
        dw[0] = fill(8'hFF); dm[0] = 2'd0;
        dw[1] = fill(8'h09); dw[1][39:32] = 8'h00; dm[1] = 2'd0;
        dw[2] = '0; dw[2][39:32] = 8'h10; dm[2] = 2'd1;
        dw[3] = fill(8'hFF); dm[3] = 2'd1;
        dw[4] = '0; dw[4][23:16] = 8'hFF; dw[4][47:40] = 8'hFF; dw[4][71:64] = 8'hFF; dm[4] = 2'd2;
        dw[5] = fill(8'h80); dm[5] = 2'd2;
        dw[6] = rnd_win(); dm[6] = 2'd3;
        dw[7] = fill(8'h00); dw[7][7:0] = 8'hFF; dm[7] = 2'd2;
        for (int i = 0; i < 8; i++) begin
            reset_n(1);
            cyc(0, 1, dw[i], dm[i]);
            idle_n(5);
        end

        // passthrough frame of 8 back-to-back windows, then mode switch mid-frame
        reset_n(1);
        for (int i = 1; i <= 8; i++) begin
            dv = rnd_win(); dv[39:32] = 8'(i);
            cyc(0, 1, dv, (i > 4) ? 2'd0 : 2'd3);
        end
        idle_n(5);
        for (int i = 0; i < 10; i++) cyc(0, 1, rnd_win(), 2'd0);
        idle_n(6);

        // reset with two windows in flight
        cyc(0, 1, rnd_win(), 2'd1);
        cyc(0, 1, rnd_win(), 2'd1);
        reset_n(1);
        idle_n(5);
        for (int i = 0; i < 8; i++) cyc(0, 1, rnd_win(), 2'd3);
        idle_n(5);

        // random streaming, including frame-boundary mode latches and rare resets
        for (int i = 0; i < 1500; i++) begin
            dv = ($urandom_range(0, 9) == 0) ? fill(8'hFF) : rnd_win();
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 75), dv,
                2'($urandom_range(0, 3)));
        end
        idle_n(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
